// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: PC -> imem req/ack -> decoder hold register, plus PC write-back.
// Latency: ir_valid 2 edges after S_REQ with zero-wait memory; redirect reaches imem_addr 3 edges later.
// Backpressure: dec_ready low holds the instruction register and stalls fetch; imem_ack may be delayed arbitrarily.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_ADDR = 32'h00003000,
    parameter logic [31:0] STEP       = 32'd4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] currentAddress,
    output logic        pcW,
    output logic [31:0] newAddress,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    output logic [31:0] ir_data,
    output logic [31:0] ir_pc,
    input  logic        dec_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_UPD} state_t;

    state_t      state, state_nxt;
    logic        pcw_nxt;
    logic [31:0] naddr_nxt;
    logic [31:0] iaddr_nxt;
    logic        irv_nxt;
    logic [31:0] ird_nxt;
    logic [31:0] irpc_nxt;
    logic        pend, pend_nxt;
    logic [31:0] pend_tgt, pend_tgt_nxt;
    logic [31:0] tgt;

    // Instruction addresses are word aligned; drop the low bits of any redirect.
    assign tgt      = redirect_target & 32'hFFFF_FFFC;
    assign imem_req = (state == S_WAIT);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= S_REQ;
            pcW        <= 1'b0;
            newAddress <= RESET_ADDR;
            imem_addr  <= 32'h0;
            ir_valid   <= 1'b0;
            ir_data    <= 32'h0;
            ir_pc      <= 32'h0;
            pend       <= 1'b0;
            pend_tgt   <= 32'h0;
        end else begin
            state      <= state_nxt;
            pcW        <= pcw_nxt;
            newAddress <= naddr_nxt;
            imem_addr  <= iaddr_nxt;
            ir_valid   <= irv_nxt;
            ir_data    <= ird_nxt;
            ir_pc      <= irpc_nxt;
            pend       <= pend_nxt;
            pend_tgt   <= pend_tgt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pcw_nxt      = pcW;
        naddr_nxt    = newAddress;
        iaddr_nxt    = imem_addr;
        irv_nxt      = ir_valid;
        ird_nxt      = ir_data;
        irpc_nxt     = ir_pc;
        pend_nxt     = pend;
        pend_tgt_nxt = pend_tgt;
        case (state)
            S_REQ: begin
                if (redirect_valid) begin
                    pcw_nxt   = 1'b1;
                    naddr_nxt = tgt;
                    state_nxt = S_UPD;
                end else begin
                    iaddr_nxt = currentAddress;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    // A redirect seen while the fetch was outstanding squashes the returned word.
                    if (redirect_valid || pend) begin
                        pcw_nxt   = 1'b1;
                        naddr_nxt = redirect_valid ? tgt : pend_tgt;
                        pend_nxt  = 1'b0;
                        state_nxt = S_UPD;
                    end else begin
                        ird_nxt   = imem_rdata;
                        irpc_nxt  = imem_addr;
                        irv_nxt   = 1'b1;
                        pcw_nxt   = 1'b1;
                        naddr_nxt = imem_addr + STEP;
                        state_nxt = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    pend_nxt     = 1'b1;
                    pend_tgt_nxt = tgt;
                end
            end
            S_HOLD: begin
                pcw_nxt = 1'b0;
                if (redirect_valid) begin
                    irv_nxt   = 1'b0;
                    pcw_nxt   = 1'b1;
                    naddr_nxt = tgt;
                    state_nxt = S_UPD;
                end else if (dec_ready) begin
                    irv_nxt   = 1'b0;
                    state_nxt = S_REQ;
                end
            end
            S_UPD: begin
                if (redirect_valid) begin
                    pcw_nxt   = 1'b1;
                    naddr_nxt = tgt;
                end else begin
                    pcw_nxt   = 1'b0;
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

endmodule
